divider: RTL and testbench

Sequential restoring divider: the inverse operation of the team's shift-add `multiplier`. It takes a 2N-bit dividend (the width of a multiplier product `PR`) and an N-bit divisor, and produces a 2N-bit quotient and an N-bit remainder, one quotient bit per clock. It sits beside `multiplier` in the arithmetic datapath. Verification benches feed `multiplier` products back through it to check the round trip.

---
 rtl/divider_pkg.sv | 20 ++
 rtl/divider_step.sv | 42 ++++
 rtl/divider.sv | 184 ++++++++++++++++++
 tb/tb_divider.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// divider_pkg: shared types and constants for the sequential restoring divider.
//   state_t        - controller states (IDLE, RUN, DONE)
//   DIV_N_DEFAULT  - default divisor/remainder width N
//   div_iters(n)   - iteration count 2N for a given N (one quotient bit per clock)
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIV_N_DEFAULT = 32'sd8;

  // Number of RUN iterations for a divider of width n.
  function automatic int div_iters(input int n);
    return 32'sd2 * n;
  endfunction

endpackage

// File: rtl/divider_step.sv
// divider_step: one combinational restoring-division iteration.
//   p       in  N+1  current partial remainder
//   dbit    in  1    next dividend bit (MSB-first)
//   divisor in  N    working divisor
//   p_next  out N+1  partial remainder after this iteration
//   qbit    out 1    quotient bit produced by this iteration
module divider_step
  import divider_pkg::*;
#(
  parameter int N = DIV_N_DEFAULT
) (
  input  logic [N:0]   p,
  input  logic         dbit,
  input  logic [N-1:0] divisor,
  output logic [N:0]   p_next,
  output logic         qbit
);

  logic [N:0] t_s;
  logic [N:0] dvs_ext_s;
  // The remainder is always below the divisor after a step, so the MSB of p
  // is structurally zero and does not take part in the shift.
  logic       unused_msb_s;

  assign unused_msb_s = p[N];
  assign t_s          = {p[N-1:0], dbit};
  assign dvs_ext_s    = {1'b0, divisor};

  // Trial subtraction: keep the difference only when it does not underflow.
  always_comb begin
    p_next = t_s;
    qbit   = 1'b0;
    if (t_s >= dvs_ext_s) begin
      p_next = t_s - dvs_ext_s;
      qbit   = 1'b1;
    end else begin
      p_next = t_s;
      qbit   = 1'b0;
    end
  end

endmodule

// File: rtl/divider.sv
// divider: sequential unsigned restoring divider, one quotient bit per clock.
// Divides a 2N-bit dividend by an N-bit divisor giving a 2N-bit quotient and
// an N-bit remainder; DR = QR*BR + RR with RR < BR whenever BR != 0.
//   clk   in  1   clock, rising edge
//   rst   in  1   synchronous active-high reset, highest priority
//   start in  1   request, accepted in IDLE or DONE
//   DR    in  2N  dividend, captured on accepted start
//   BR    in  N   divisor, captured on accepted start
//   QR    out 2N  quotient, updated on completion only
//   RR    out N   remainder, updated on completion only
//   busy  out 1   division in progress
//   done  out 1   one-cycle pulse when QR/RR were just updated
//   dz    out 1   last result was a divide-by-zero
// Build option: DIVIDER_DIVZERO_EN - when defined, a zero divisor completes
// immediately with dz=1; otherwise it runs all iterations and dz is tied 0.
// Result values are the same either way.
module divider
  import divider_pkg::*;
#(
  parameter int N = DIV_N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] DR,
  input  logic [N-1:0]   BR,
  output logic [2*N-1:0] QR,
  output logic [N-1:0]   RR,
  output logic           busy,
  output logic           done,
  output logic           dz
);

  localparam int              ITERS    = div_iters(N);
  localparam int              CW       = $clog2(ITERS);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(ITERS - 32'sd1);

  state_t         state_r, state_s;
  logic [2*N-1:0] dvd_r,   dvd_s;
  logic [N-1:0]   dvs_r,   dvs_s;
  logic [N:0]     p_r,     p_s;
  logic [2*N-1:0] quo_r,   quo_s;
  logic [CW-1:0]  cnt_r,   cnt_s;
  logic [2*N-1:0] qr_r,    qr_s;
  logic [N-1:0]   rr_r,    rr_s;
  logic           busy_r,  busy_s;
  logic           done_r,  done_s;

  logic [N:0]     p_step_s;
  logic           q_step_s;
  logic [2*N-1:0] quo_step_s;

`ifdef DIVIDER_DIVZERO_EN
  logic           dz_r, dz_s;
  assign dz = dz_r;
`else
  assign dz = 1'b0;
`endif

  assign QR   = qr_r;
  assign RR   = rr_r;
  assign busy = busy_r;
  assign done = done_r;

  divider_step #(
    .N(N)
  ) u_step (
    .p      (p_r),
    .dbit   (dvd_r[2*N-1]),
    .divisor(dvs_r),
    .p_next (p_step_s),
    .qbit   (q_step_s)
  );

  assign quo_step_s = {quo_r[2*N-2:0], q_step_s};

  // Next-state and next-register logic for the controller and datapath.
  always_comb begin
    state_s = state_r;
    dvd_s   = dvd_r;
    dvs_s   = dvs_r;
    p_s     = p_r;
    quo_s   = quo_r;
    cnt_s   = cnt_r;
    qr_s    = qr_r;
    rr_s    = rr_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
`ifdef DIVIDER_DIVZERO_EN
    dz_s    = dz_r;
`endif
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          dvd_s   = DR;
          dvs_s   = BR;
          p_s     = '0;
          quo_s   = '0;
          cnt_s   = CNT_LOAD;
          busy_s  = 1'b1;
          state_s = RUN;
`ifdef DIVIDER_DIVZERO_EN
          // Zero divisor: publish the natural all-ones result at once.
          if (BR == '0) begin
            qr_s    = '1;
            rr_s    = DR[N-1:0];
            dz_s    = 1'b1;
            done_s  = 1'b1;
            busy_s  = 1'b0;
            state_s = DONE;
          end else begin
            state_s = RUN;
          end
`endif
        end else begin
          busy_s  = 1'b0;
          state_s = IDLE;
        end
      end
      RUN: begin
        dvd_s = {dvd_r[2*N-2:0], 1'b0};
        p_s   = p_step_s;
        quo_s = quo_step_s;
        if (cnt_r == '0) begin
          qr_s    = quo_step_s;
          rr_s    = p_step_s[N-1:0];
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = DONE;
`ifdef DIVIDER_DIVZERO_EN
          dz_s    = 1'b0;
`endif
        end else begin
          cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Working, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_r  <= '0;
      dvs_r  <= '0;
      p_r    <= '0;
      quo_r  <= '0;
      cnt_r  <= '0;
      qr_r   <= '0;
      rr_r   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
`ifdef DIVIDER_DIVZERO_EN
      dz_r   <= 1'b0;
`endif
    end else begin
      dvd_r  <= dvd_s;
      dvs_r  <= dvs_s;
      p_r    <= p_s;
      quo_r  <= quo_s;
      cnt_r  <= cnt_s;
      qr_r   <= qr_s;
      rr_r   <= rr_s;
      busy_r <= busy_s;
      done_r <= done_s;
`ifdef DIVIDER_DIVZERO_EN
      dz_r   <= dz_s;
`endif
    end
  end

endmodule

// File: tb/tb_divider.sv
// tb_divider: scoreboard bench for divider (N=8). Stimulus pushes the
// hand-computed result and the cycle at which done must appear; a monitor
// pops and compares whenever done is seen.
module tb_divider;

  localparam int ITERS = 16;
`ifdef DIVIDER_DIVZERO_EN
  localparam logic DZ_EN = 1'b1;
`else
  localparam logic DZ_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    int          cyc;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dr    = 16'd0;
  logic [7:0]  br    = 8'd0;
  logic [15:0] qr;
  logic [7:0]  rr;
  logic        busy;
  logic        done;
  logic        dz;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];

  divider #(.N(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .DR   (dr),
    .BR   (br),
    .QR   (qr),
    .RR   (rr),
    .busy (busy),
    .done (done),
    .dz   (dz)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("qr", {16'd0, qr}, {16'd0, e.q});
        check("rr", {24'd0, rr}, {24'd0, e.r});
        check("dz", {31'd0, dz}, {31'd0, e.dz});
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Issue one division from a negedge; the accepting edge is the next posedge.
  task automatic do_div(input logic [15:0] a, input logic [7:0] b, input logic [15:0] eq,
                        input logic [7:0] er, input logic edz, input int lat);
    exp_t e;
    e.q   = eq;
    e.r   = er;
    e.dz  = edz;
    e.cyc = cyc + 1 + lat;
    sb.push_back(e);
    dr    = a;
    br    = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=%0d_pending required=0_pending", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_done_cycle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_done actual=0 required=1");
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_qr",   {16'd0, qr},   32'd0);
    check("rst_rr",   {24'd0, rr},   32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dz",   {31'd0, dz},   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Multiplier round trip: 204*170 = 34680.
    do_div(16'd34680, 8'd170, 16'd204, 8'd0, 1'b0, ITERS);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    wait_idle();

    do_div(16'd1000,  8'd7,   16'd142,   8'd6, 1'b0, ITERS);
    wait_idle();
    do_div(16'd5,     8'd200, 16'd0,     8'd5, 1'b0, ITERS);
    wait_idle();
    do_div(16'd65535, 8'd1,   16'd65535, 8'd0, 1'b0, ITERS);
    wait_idle();

    // Zero divisor: same values in both builds; latency and dz differ.
    do_div(16'd1234, 8'd0, 16'hFFFF, 8'hD2, DZ_EN, DZ_EN ? 0 : ITERS);
    wait_idle();

    // start with new operands mid-RUN is ignored; outputs hold old values.
    do_div(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, ITERS);
    repeat (3) @(negedge clk);
    dr    = 16'd5;
    br    = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("hold_qr",   {16'd0, qr},   32'h0000FFFF);
    check("hold_rr",   {24'd0, rr},   32'h000000D2);
    check("hold_busy", {31'd0, busy}, 32'd1);
    wait_idle();

    // Reset at iteration 5 aborts with no done pulse.
    dr    = 16'd65535;
    br    = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_qr",   {16'd0, qr},   32'd0);
    check("abort_rr",   {24'd0, rr},   32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_dz",   {31'd0, dz},   32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    do_div(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, ITERS);
    wait_idle();

    // Back-to-back: second start issued in the DONE cycle of the first.
    do_div(16'd34680, 8'd170, 16'd204, 8'd0, 1'b0, ITERS);
    wait_done_cycle();
    do_div(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, ITERS);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
